tug_rope_ctrl: RTL and testbench

Game controller directly downstream of the push-button latch. It consumes the latch's `push`/`tie`/`right` flags, lets them settle, moves the rope-position LED one step toward the player who pressed first, and detects a win at either end. It drives `clear` back to the latch to re-arm it, and keeps a saturating win count per player.

---
 rtl/tug_rope_ctrl.sv | 112 +++++++++++
 tb/tb_tug_rope_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tug_rope_ctrl.sv
// tug_rope_ctrl: tug-of-war game controller behind the push-button latch
// Ports:
//   clk                    system clock, rising edge
//   rst                    asynchronous active-low reset
//   push, tie, right       latch flags (any press / both pressed / right first)
//   new_game               level; recentres the rope and re-arms the latch
//   clear                  registered latch re-arm, high in CLEAR and WIN
//   leds[NLEDS-1:0]        one-hot rope position, bit 0 is the left end
//   win_l, win_r           high while the game is won by that player
//   score_l, score_r       saturating 4-bit win counters
// Optional macro TUG_BLINK_EN: blink the end LED while in WIN.
module tug_rope_ctrl #(
    parameter int NLEDS      = 9,
    parameter int SETTLE_CYC = 4,
    parameter int BLINK_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             tie,
    input  logic             right,
    input  logic             new_game,
    output logic             clear,
    output logic [NLEDS-1:0] leds,
    output logic             win_l,
    output logic             win_r,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r
);
    localparam int PW = $clog2(NLEDS);
    localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam logic [PW-1:0] CPOS  = PW'((NLEDS - 1) / 2);
    localparam logic [PW-1:0] LAST  = PW'(NLEDS - 1);
    localparam logic [CW-1:0] CLAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CLEAR, WIN} state_t;

    state_t          state;
    logic [PW-1:0]   pos;
    logic [PW-1:0]   nxt;
    logic [CW-1:0]   cnt;
    logic [NLEDS-1:0] onehot;

    always_comb nxt = tie ? pos : (right ? pos + 1'b1 : pos - 1'b1);
    assign onehot = NLEDS'(1) << pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pos     <= CPOS;
            cnt     <= '0;
            clear   <= 1'b0;
            win_l   <= 1'b0;
            win_r   <= 1'b0;
            score_l <= '0;
            score_r <= '0;
        end else if (new_game) begin
            state <= CLEAR;
            pos   <= CPOS;
            cnt   <= '0;
            clear <= 1'b1;
            win_l <= 1'b0;
            win_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (push) begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
                SETTLE: if (cnt == CLAST) begin
                    // push may have dropped meanwhile; the decision uses only tie/right now
                    pos   <= nxt;
                    cnt   <= '0;
                    clear <= 1'b1;
                    if (nxt == LAST) begin
                        state   <= WIN;
                        win_r   <= 1'b1;
                        score_r <= score_r + {3'b0, score_r != 4'hf};
                    end else if (nxt == '0) begin
                        state   <= WIN;
                        win_l   <= 1'b1;
                        score_l <= score_l + {3'b0, score_l != 4'hf};
                    end else begin
                        state <= CLEAR;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                CLEAR: if (!push) begin
                    state <= IDLE;
                    clear <= 1'b0;
                end
                WIN: ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TUG_BLINK_EN
    // held at 0 outside WIN, so it starts from 0 on every WIN entry
    logic [BLINK_LOG2:0] blink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink <= '0;
        else blink <= (state == WIN) ? blink + 1'b1 : '0;
    end

    assign leds = (state == WIN && blink[BLINK_LOG2]) ? '0 : onehot;
`else
    assign leds = onehot;
`endif
endmodule

// File: tb/tb_tug_rope_ctrl.sv
// tb_tug_rope_ctrl: directed bench with a timestamp-based game model
module tb_tug_rope_ctrl;
    localparam int N  = 9;
    localparam int C  = 4;
    localparam int ST = 4;
    localparam int BL = 3;

    logic clk = 0, rst = 1, push = 0, tie = 0, right = 0, new_game = 0;
    logic clear, win_l, win_r;
    logic [N-1:0] leds;
    logic [3:0] score_l, score_r;

    int npass = 0, ntot = 0;
    bit chk_en = 0;

    tug_rope_ctrl #(.NLEDS(N), .SETTLE_CYC(ST), .BLINK_LOG2(BL)) dut (
        .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
        .new_game(new_game), .clear(clear), .leds(leds),
        .win_l(win_l), .win_r(win_r), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    // Model: a pending press is a future decision time; the game is
    // armed when nothing is pending and the latch is not held in clear.
    int cyc, m_pos, m_sl, m_sr, m_dec, m_wcyc;
    bit m_wl, m_wr, m_clr;

    always @(posedge clk or negedge rst) begin : model
        int np;
        if (!rst) begin
            cyc <= 0; m_pos <= C; m_sl <= 0; m_sr <= 0; m_dec <= -1;
            m_wl <= 0; m_wr <= 0; m_clr <= 0; m_wcyc <= 0;
        end else begin
            np = m_pos + (tie ? 0 : (right ? 1 : -1));
            if (new_game) begin
                m_pos <= C; m_wl <= 0; m_wr <= 0; m_clr <= 1; m_dec <= -1;
            end else if (m_dec == cyc) begin
                m_pos <= np; m_dec <= -1; m_clr <= 1;
                if (np == N - 1) begin
                    m_wr <= 1; m_sr <= (m_sr == 15) ? 15 : m_sr + 1; m_wcyc <= cyc;
                end else if (np == 0) begin
                    m_wl <= 1; m_sl <= (m_sl == 15) ? 15 : m_sl + 1; m_wcyc <= cyc;
                end
            end else if (m_dec < 0 && !m_clr && push) begin
                m_dec <= cyc + ST;
            end else if (m_clr && !m_wl && !m_wr && !push) begin
                m_clr <= 0;
            end
            cyc <= cyc + 1;
        end
    end

    function automatic int exp_leds();
        int b;
        b = cyc - m_wcyc - 1;
`ifdef TUG_BLINK_EN
        if ((m_wl || m_wr) && b[BL]) return 0;
`endif
        return 1 << m_pos;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("cyc_leds", int'(leds), exp_leds());
            chk("cyc_clear", int'(clear), int'(m_clr));
            chk("cyc_win_l", int'(win_l), int'(m_wl));
            chk("cyc_win_r", int'(win_r), int'(m_wr));
            chk("cyc_score_l", int'(score_l), m_sl);
            chk("cyc_score_r", int'(score_r), m_sr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ng();
        new_game = 1;
        tick();
        new_game = 0;
        tick();
    endtask

    task automatic press(input bit r, input bit t);
        int i;
        push = 1; right = r; tie = t;
        for (i = 0; i < 20 && !(clear || win_l || win_r); i++) tick();
        chk("press_taken", int'(clear || win_l || win_r), 1);
        push = 0; right = 0; tie = 0;
        if (win_l || win_r) return;
        for (i = 0; i < 20 && clear; i++) tick();
        chk("press_rearm", int'(clear), 0);
        tick();
    endtask

    initial begin
        #3 rst = 0;
        #1;
        chk("rst_leds", int'(leds), 9'b000010000);
        chk("rst_clear", int'(clear), 0);
        chk("rst_scores", int'({score_l, score_r}), 0);
        tick(); tick();
        rst = 1;
        chk_en = 1;
        tick();

        // right press with exact latency
        push = 1; right = 1;
        tick();
        tick(); tick(); tick();
        chk("pre_move_leds", int'(leds), 9'b000010000);
        tick();
        chk("move_r_leds", int'(leds), 9'b000100000);
        chk("move_r_clear", int'(clear), 1);
        push = 0; right = 0;
        tick();
        chk("clear_fall", int'(clear), 0);
        tick();

        // tie then left from centre
        ng();
        press(0, 1);
        chk("tie_leds", int'(leds), 9'b000010000);
        press(0, 0);
        chk("left_leds", int'(leds), 9'b000001000);

        // right win, ignored presses, new game
        ng();
        for (int k = 0; k < 4; k++) press(1, 0);
        chk("win_leds", int'(leds), 9'b100000000);
        chk("win_r", int'(win_r), 1);
        chk("win_score_r", int'(score_r), 1);
        chk("win_clear", int'(clear), 1);
        push = 1; right = 0;
        repeat (20) tick();
        push = 0;
        chk("win_hold", int'(win_r), 1);
        ng();
        chk("ng_leds", int'(leds), 9'b000010000);
        chk("ng_win_r", int'(win_r), 0);
        chk("ng_score_r", int'(score_r), 1);

        // sixteen left wins saturate
        for (int g = 0; g < 16; g++) begin
            ng();
            for (int k = 0; k < 4; k++) press(0, 0);
        end
        chk("sat_score_l", int'(score_l), 15);
        chk("sat_win_l", int'(win_l), 1);

        // new_game on the decision edge overrides the move
        ng();
        push = 1; right = 1;
        tick(); tick(); tick(); tick();
        new_game = 1;
        tick();
        chk("ng_dec_leds", int'(leds), 9'b000010000);
        chk("ng_dec_clear", int'(clear), 1);
        new_game = 0; push = 0; right = 0;
        tick(); tick();

        // async reset mid-SETTLE
        push = 1; right = 1;
        tick(); tick();
        rst = 0;
        #1;
        chk("arst_leds", int'(leds), 9'b000010000);
        chk("arst_clear", int'(clear), 0);
        chk("arst_scores", int'({score_l, score_r}), 0);
        push = 0; right = 0;
        tick();
        rst = 1;
        tick();

        // push dropped during SETTLE with all flags low counts as left
        push = 1;
        tick();
        push = 0;
        for (int i = 0; i < 20 && !clear; i++) tick();
        chk("drop_leds", int'(leds), 9'b000001000);
        tick(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
